// File: rtl/lsu_pkg.sv
// Shared types and default address map for the RV32E load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10,
        LSU_RSVD = 2'b11
    } lsu_width_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        FAULT
    } lsu_state_e;

    localparam int NUM_REGIONS_DEF = 3;

    // Region 0 occupies the least significant 32 bits.
    localparam logic [95:0] REGION_BASE_DEF  = {32'h0000_5000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [95:0] REGION_LIMIT_DEF = {32'h0000_8FFF, 32'h0000_4FFF, 32'h0000_0FFF};

    localparam int RGN_ITCM = 0;
    localparam int RGN_DTCM = 1;
    localparam int RGN_CSR  = 2;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables / replicated data and load shift / extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_width_e  width,
    input  logic [1:0]  addr_lo,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = shifted;
        case (width)
            LSU_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            LSU_HALF: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_region_ctrl.sv
// Region-decoding load/store unit with a req/gnt/rvalid bus interface.
// Define LSU_ACCESS_FAULT_EN to turn unmapped/misaligned/reserved-width accesses into faults.
module lsu_region_ctrl
    import lsu_pkg::*;
#(
    parameter int                          NUM_REGIONS  = NUM_REGIONS_DEF,
    parameter logic [NUM_REGIONS*32-1:0]   REGION_BASE  = REGION_BASE_DEF,
    parameter logic [NUM_REGIONS*32-1:0]   REGION_LIMIT = REGION_LIMIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic                   lsu_we,
    input  logic                   lsu_sext,
    input  logic [1:0]             lsu_width,
    input  logic [31:0]            lsu_addr,
    input  logic [31:0]            lsu_wdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   mem_req,
    output logic [NUM_REGIONS-1:0] mem_sel,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [3:0]             mem_be,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [31:0]            mem_rdata
);

    logic [NUM_REGIONS-1:0] hit;
    logic [NUM_REGIONS-1:0] sel_next;
    logic                   unmapped;
    lsu_width_e             width_in;
    lsu_width_e             eff_width;
    logic [1:0]             eff_lo;
    logic                   skip_bus;
    logic                   err_flag;

    lsu_state_e             state_reg;
    logic                   ready_reg, req_reg, we_reg, sext_reg;
    lsu_width_e             width_reg;
    logic [1:0]             addr_lo_reg;
    logic [31:0]            addr_reg, wdata_reg;
    logic [NUM_REGIONS-1:0] sel_reg;
    logic                   rsp_valid_reg, rsp_err_reg;
    logic [31:0]            rsp_rdata_reg;

    logic [3:0]             be;
    logic [31:0]            wdata_rep, rdata_ext;

    // Offset-from-base compare avoids constant-true checks when a base is zero.
    generate
        for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            assign hit[gi] = (lsu_addr - REGION_BASE[gi*32 +: 32]) <=
                             (REGION_LIMIT[gi*32 +: 32] - REGION_BASE[gi*32 +: 32]);
        end
    endgenerate

    always_comb begin
        sel_next = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_next    = '0;
                sel_next[i] = 1'b1;
            end
        end
    end

    assign unmapped = ~|hit;
    assign width_in = lsu_width_e'(lsu_width);

`ifdef LSU_ACCESS_FAULT_EN
    logic misaligned;
    assign misaligned = (width_in == LSU_HALF && lsu_addr[0]) ||
                        (width_in == LSU_WORD && lsu_addr[1:0] != 2'b00);
    assign eff_width  = width_in;
    assign eff_lo     = lsu_addr[1:0];
    assign skip_bus   = unmapped | misaligned | (width_in == LSU_RSVD);
    assign err_flag   = skip_bus;
`else
    assign eff_width  = (width_in == LSU_RSVD) ? LSU_WORD : width_in;
    always_comb begin
        case (eff_width)
            LSU_BYTE: eff_lo = lsu_addr[1:0];
            LSU_HALF: eff_lo = {lsu_addr[1], 1'b0};
            default:  eff_lo = 2'b00;
        endcase
    end
    assign skip_bus   = unmapped;
    assign err_flag   = 1'b0;
`endif

    lsu_lane_align u_align (
        .width     (width_reg),
        .addr_lo   (addr_lo_reg),
        .sext      (sext_reg),
        .wdata     (wdata_reg),
        .rdata     (mem_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b1;
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            sext_reg      <= 1'b0;
            width_reg     <= LSU_BYTE;
            addr_lo_reg   <= 2'b00;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            sel_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (lsu_valid) begin
                        ready_reg   <= 1'b0;
                        we_reg      <= lsu_we;
                        sext_reg    <= lsu_sext;
                        width_reg   <= eff_width;
                        addr_lo_reg <= eff_lo;
                        wdata_reg   <= lsu_wdata;
                        if (skip_bus) begin
                            state_reg     <= err_flag ? FAULT : DONE;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= err_flag;
                            rsp_rdata_reg <= '0;
                        end else begin
                            state_reg <= REQ;
                            req_reg   <= 1'b1;
                            sel_reg   <= sel_next;
                            addr_reg  <= {lsu_addr[31:2], 2'b00};
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        req_reg <= 1'b0;
                        if (we_reg) begin
                            state_reg     <= DONE;
                            rsp_valid_reg <= 1'b1;
                            rsp_rdata_reg <= '0;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_reg     <= DONE;
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= rdata_ext;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    ready_reg     <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                    rsp_err_reg   <= 1'b0;
                    rsp_rdata_reg <= '0;
                end
            endcase
        end
    end

    assign lsu_ready = ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign mem_req   = req_reg;
    assign mem_sel   = sel_reg;
    assign mem_addr  = addr_reg;
    assign mem_we    = req_reg & we_reg;
    assign mem_be    = req_reg ? be : 4'b0000;
    assign mem_wdata = (req_reg & we_reg) ? wdata_rep : 32'h0;

endmodule

// File: tb/tb_lsu_region_ctrl.sv
// Directed bench for lsu_region_ctrl; expectations follow LSU_ACCESS_FAULT_EN when defined.
module tb_lsu_region_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_valid = 1'b0, lsu_we = 1'b0, lsu_sext = 1'b0;
    logic [1:0]  lsu_width = 2'b00;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic        lsu_ready, rsp_valid, rsp_err, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_sel;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_region_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we), .lsu_sext(lsu_sext),
        .lsu_width(lsu_width), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic        sext;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        bus;
        logic [2:0]  sel;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Gnt in the first REQ cycle, rvalid in the cycle after gnt.
    task automatic run_vec(input vec_t v, input string t);
        lsu_valid = 1'b1; lsu_we = v.we; lsu_sext = v.sext; lsu_width = v.width;
        lsu_addr = v.addr; lsu_wdata = v.wdata;
        chk({t, ".ready_in"}, 32'(lsu_ready), 32'd1);
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        if (v.bus) begin
            chk({t, ".req"}, 32'(mem_req), 32'd1);
            chk({t, ".sel"}, 32'(mem_sel), 32'(v.sel));
            chk({t, ".be"}, 32'(mem_be), 32'(v.be));
            chk({t, ".addr"}, mem_addr, v.maddr);
            chk({t, ".we"}, 32'(mem_we), 32'(v.we));
            if (v.we) chk({t, ".wdata"}, mem_wdata, v.mwdata);
            chk({t, ".ready_busy"}, 32'(lsu_ready), 32'd0);
            mem_gnt = 1'b1;
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            if (!v.we) begin
                chk({t, ".no_early_rsp"}, 32'(rsp_valid), 32'd0);
                mem_rvalid = 1'b1; mem_rdata = v.rdata;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end
        end
        chk({t, ".no_req"}, 32'(mem_req), 32'd0);
        chk({t, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({t, ".rsp_err"}, 32'(rsp_err), 32'(v.err));
        chk({t, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({t, ".ready_rsp"}, 32'(lsu_ready), 32'd0);
        $display("[TB] txn %s we=%0d w=%0d addr=%h rdata=%h err=%0d", t, v.we, v.width,
                 v.addr, rsp_rdata, rsp_err);
        @(posedge clk); #1;
        chk({t, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
        chk({t, ".ready_back"}, 32'(lsu_ready), 32'd1);
    endtask

    task automatic chk_quiet(input string t);
        chk({t, ".ready"}, 32'(lsu_ready), 32'd1);
        chk({t, ".req"}, 32'(mem_req), 32'd0);
        chk({t, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({t, ".rsp_err"}, 32'(rsp_err), 32'd0);
        chk({t, ".rsp_rdata"}, rsp_rdata, 32'd0);
        chk({t, ".sel"}, 32'(mem_sel), 32'd0);
        chk({t, ".addr"}, mem_addr, 32'd0);
        chk({t, ".be"}, 32'(mem_be), 32'd0);
        chk({t, ".wdata"}, mem_wdata, 32'd0);
        chk({t, ".we"}, 32'(mem_we), 32'd0);
    endtask

    initial begin
        //               we    sext  w      addr          wdata         rdata         bus   sel     be       maddr         mwdata        err   exp_rdata
        vecs.push_back('{1'b1, 1'b0, 2'b00, 32'h0000_1003, 32'h0000_00A5, 32'h0,        1'b1, 3'b010, 4'b1000, 32'h0000_1000, 32'hA5A5_A5A5, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 2'b01, 32'h0000_5002, 32'h0,        32'h8001_1234, 1'b1, 3'b100, 4'b1100, 32'h0000_5000, 32'h0,        1'b0, 32'hFFFF_8001});
        vecs.push_back('{1'b0, 1'b0, 2'b01, 32'h0000_5002, 32'h0,        32'h8001_1234, 1'b1, 3'b100, 4'b1100, 32'h0000_5000, 32'h0,        1'b0, 32'h0000_8001});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 32'h0000_0001, 32'h0,        32'h1234_56F0, 1'b1, 3'b001, 4'b0010, 32'h0000_0000, 32'h0,        1'b0, 32'h0000_0056});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 32'h0000_0003, 32'h0,        32'h8012_3456, 1'b1, 3'b001, 4'b1000, 32'h0000_0000, 32'h0,        1'b0, 32'hFFFF_FF80});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 32'h0000_0FFF, 32'h0,        32'h7F00_0000, 1'b1, 3'b001, 4'b1000, 32'h0000_0FFC, 32'h0,        1'b0, 32'h0000_007F});
        vecs.push_back('{1'b0, 1'b1, 2'b10, 32'h0000_2000, 32'h0,        32'hDEAD_BEEF, 1'b1, 3'b010, 4'b1111, 32'h0000_2000, 32'h0,        1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 32'h0000_8FFE, 32'h1234_ABCD, 32'h0,        1'b1, 3'b100, 4'b1100, 32'h0000_8FFC, 32'hABCD_ABCD, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 32'h0000_4FFC, 32'hCAFE_F00D, 32'h0,        1'b1, 3'b010, 4'b1111, 32'h0000_4FFC, 32'hCAFE_F00D, 1'b0, 32'h0});
`ifdef LSU_ACCESS_FAULT_EN
        vecs.push_back('{1'b0, 1'b0, 2'b10, 32'h0000_1002, 32'h0,        32'h1122_3344, 1'b0, 3'b000, 4'b0000, 32'h0,        32'h0,        1'b1, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 2'b10, 32'h0000_9000, 32'h0,        32'h1122_3344, 1'b0, 3'b000, 4'b0000, 32'h0,        32'h0,        1'b1, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 2'b11, 32'h0000_2004, 32'h0,        32'h5566_7788, 1'b0, 3'b000, 4'b0000, 32'h0,        32'h0,        1'b1, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 32'h0000_1001, 32'h0000_BEEF, 32'h0,        1'b0, 3'b000, 4'b0000, 32'h0,        32'h0,        1'b1, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0,        32'h0,        1'b0, 3'b000, 4'b0000, 32'h0,        32'h0,        1'b1, 32'h0});
`else
        vecs.push_back('{1'b0, 1'b0, 2'b10, 32'h0000_1002, 32'h0,        32'h1122_3344, 1'b1, 3'b010, 4'b1111, 32'h0000_1000, 32'h0,        1'b0, 32'h1122_3344});
        vecs.push_back('{1'b0, 1'b0, 2'b10, 32'h0000_9000, 32'h0,        32'h1122_3344, 1'b0, 3'b000, 4'b0000, 32'h0,        32'h0,        1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 2'b11, 32'h0000_2004, 32'h0,        32'h5566_7788, 1'b1, 3'b010, 4'b1111, 32'h0000_2004, 32'h0,        1'b0, 32'h5566_7788});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 32'h0000_1001, 32'h0000_BEEF, 32'h0,        1'b1, 3'b010, 4'b0011, 32'h0000_1000, 32'hBEEF_BEEF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0,        32'h0,        1'b0, 3'b000, 4'b0000, 32'h0,        32'h0,        1'b0, 32'h0});
`endif

        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_quiet("post_reset");

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Grant withheld for five cycles: request fields must hold.
        lsu_valid = 1'b1; lsu_we = 1'b0; lsu_sext = 1'b0; lsu_width = 2'b10;
        lsu_addr = 32'h0000_1004;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("stall.req", 32'(mem_req), 32'd1);
            chk("stall.addr", mem_addr, 32'h0000_1004);
            chk("stall.be", 32'(mem_be), 32'hF);
            chk("stall.sel", 32'(mem_sel), 32'h2);
            chk("stall.ready", 32'(lsu_ready), 32'd0);
            chk("stall.rsp", 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("stall.req_drop", 32'(mem_req), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("stall.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall.rdata", rsp_rdata, 32'h0BAD_F00D);
        $display("[TB] txn stall addr=%h rdata=%h err=%0d", 32'h0000_1004, rsp_rdata, rsp_err);
        @(posedge clk); #1;

        // Reset asserted while waiting for read data aborts the access.
        lsu_valid = 1'b1; lsu_we = 1'b0; lsu_width = 2'b10; lsu_addr = 32'h0000_2008;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("abort.in_wait_req", 32'(mem_req), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_quiet("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("abort.no_rsp0", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("abort.no_rsp1", 32'(rsp_valid), 32'd0);
        chk("abort.ready", 32'(lsu_ready), 32'd1);
        $display("[TB] txn abort addr=%h rsp_valid=%0d", 32'h0000_2008, rsp_valid);
        run_vec(vecs[1], "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
